// File: rtl/gpio_mult_host.sv
// Bus initiator for the GPIO multiply/popcount peripheral: writes both operands,
// kicks the job, polls status, then reads back W and the ones count L.
`timescale 1ns/1ps
module gpio_mult_host #(
  parameter int STROBE_LEN = 2,
  parameter int POLL_GAP   = 8,
  parameter int MAX_POLLS  = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic [23:0] arg1,
  input  logic [23:0] arg2,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result_w,
  output logic [23:0] ones_l,
  output logic [1:0]  status_b,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);

  typedef enum logic [3:0] {
    IDLE, WR_A1, WR_A2, KICK, WAIT, POLL, RD_W0, RD_W1, RD_L, DONE
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

  localparam logic [15:0] ADDR_A1  = 16'h037F;
  localparam logic [15:0] ADDR_A2  = 16'h0388;
  localparam logic [15:0] ADDR_W   = 16'h0390;
  localparam logic [15:0] ADDR_L   = 16'h0398;
  localparam logic [15:0] ADDR_CTL = 16'h03A0;

  localparam logic [3:0] STB_LAST  = 4'(STROBE_LEN - 1);
  localparam logic [7:0] GAP_LAST  = 8'(POLL_GAP - 1);
  localparam logic [7:0] POLL_LAST = 8'(MAX_POLLS - 1);

  state_t      state;
  phase_t      phase;
  logic [3:0]  stb_cnt;
  logic [7:0]  gap_cnt;
  logic [7:0]  poll_cnt;
  logic [23:0] a2_q;
  logic        rd_access;

  assign rd_access = (state == POLL) || (state == RD_W0) ||
                     (state == RD_W1) || (state == RD_L);

  // Every access state runs SETUP -> STROBE (STROBE_LEN cycles) -> HOLD; the
  // address and write data for the next access are loaded as HOLD ends.
  always_ff @(posedge clk or negedge n_reset) begin
    // NOTE: every register is cleared here, including the captured operand, so
    // a reset mid-job leaves nothing behind that a later job could pick up.
    if (!n_reset) begin
      state    <= IDLE;
      phase    <= PH_SETUP;
      stb_cnt  <= '0;
      gap_cnt  <= '0;
      poll_cnt <= '0;
      a2_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result_w <= '0;
      ones_l   <= '0;
      status_b <= '0;
      saddress <= '0;
      srd      <= 1'b0;
      swr      <= 1'b0;
      sdata_wr <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; this default is overridden
      // only on the edge that enters DONE, giving a single-cycle pulse.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a2_q     <= arg2;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= WR_A1;
            phase    <= PH_SETUP;
            saddress <= ADDR_A1;
            sdata_wr <= {8'h0, arg1};
          end
        end
        WAIT: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= POLL;
            phase    <= PH_SETUP;
            saddress <= ADDR_CTL;
            sdata_wr <= '0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: begin
          case (phase)
            PH_SETUP: begin
              phase   <= PH_STROBE;
              stb_cnt <= '0;
              if (rd_access) srd <= 1'b1;
              else           swr <= 1'b1;
            end
            PH_STROBE: begin
              if (stb_cnt == STB_LAST) begin
                srd   <= 1'b0;
                swr   <= 1'b0;
                phase <= PH_HOLD;
              end else begin
                stb_cnt <= stb_cnt + 4'd1;
              end
            end
            default: begin
              phase <= PH_SETUP;
              case (state)
                WR_A1: begin
                  state    <= WR_A2;
                  saddress <= ADDR_A2;
                  sdata_wr <= {8'h0, a2_q};
                end
                WR_A2: begin
                  state    <= KICK;
                  saddress <= ADDR_CTL;
                  sdata_wr <= '0;
                end
                KICK: begin
                  state    <= WAIT;
                  poll_cnt <= '0;
                  gap_cnt  <= '0;
                  sdata_wr <= '0;
                end
                POLL: begin
                  status_b <= sdata_rd[1:0];
                  poll_cnt <= poll_cnt + 8'd1;
                  if (sdata_rd[1]) begin
                    state    <= RD_W0;
                    saddress <= ADDR_W;
                  end else if (poll_cnt == POLL_LAST) begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                  end else begin
                    state   <= WAIT;
                    gap_cnt <= '0;
                  end
                end
                // The peripheral refreshes W one read late, so this read is dropped.
                RD_W0: state <= RD_W1;
                RD_W1: begin
                  result_w <= sdata_rd;
                  state    <= RD_L;
                  saddress <= ADDR_L;
                end
                default: begin
                  ones_l <= sdata_rd[23:0];
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
                end
              endcase
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: doc/gpio_mult_host.md
Name: gpio_mult_host

Overview:
Bus initiator for the GPIO multiply/popcount peripheral. It drives the peripheral's strobe bus (saddress/srd/swr/data) to run one complete job: write both operands, kick the operation, poll status, then read the result word W and the ones count L. It sits between a local controller (start/busy/done handshake) and the peripheral's slave bus. It lets firmware-free logic, and the bench, exercise the peripheral end to end.

Parameters:
STROBE_LEN, 2, cycles srd/swr held high per access (1..15)
POLL_GAP, 8, idle cycles between kick and first poll and between successive polls (1..255)
MAX_POLLS, 16, status reads before timeout (1..255)

Ports:
clk  in  1  system clock, all state on rising edge
n_reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
arg1  in  24  operand A1; captured on accepted start
arg2  in  24  operand A2; captured on accepted start
busy  out  1  high from the cycle after an accepted start until DONE exits
done  out  1  one-cycle pulse at job end
err  out  1  timeout flag; valid with done, held until next accepted start
result_w  out  32  W read from 0x390
ones_l  out  24  L read from 0x398 (bits 23:0)
status_b  out  2  last B value polled from 0x3A0
saddress  out  16  bus address
srd  out  1  read strobe
swr  out  1  write strobe
sdata_wr  out  32  write data to peripheral sdata_in
sdata_rd  in  32  read data from peripheral sdata_out

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; poll counter 0; captured operands 0.
- Bus access, 2+STROBE_LEN cycles: SETUP (saddress/sdata_wr valid, strobes 0), STROBE (srd or swr = 1 for STROBE_LEN cycles, address/data stable), HOLD (strobes 0, address/data stable). Never both strobes high. Read data is sampled on the clk edge ending HOLD. Between accesses saddress holds its last value; sdata_wr is 0 during reads.
- States and transitions:
  - IDLE: on start=1, capture arg1/arg2, clear err, go to WR_A1.
  - WR_A1: write {8'h0,arg1} to 0x037F. Go to WR_A2.
  - WR_A2: write {8'h0,arg2} to 0x0388. Go to KICK.
  - KICK: write 32'h0 to 0x03A0. Clear poll counter. Go to WAIT.
  - WAIT: count POLL_GAP cycles, then go to POLL.
  - POLL: read 0x03A0; status_b <= sdata_rd[1:0]; increment poll counter.
    - If sdata_rd[1]=1, go to RD_W0.
    - Else if the counter has reached MAX_POLLS, set err=1 and go to DONE.
    - Else go to WAIT.
  - RD_W0: read 0x0390 and discard (the peripheral updates W one read late). Go to RD_W1.
  - RD_W1: read 0x0390; result_w <= sdata_rd. Go to RD_L.
  - RD_L: read 0x0398; ones_l <= sdata_rd[23:0]. Go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 in that cycle, next state IDLE.
- Timeout path: result_w and ones_l keep their previous values; status_b holds the last polled value.
- start outside IDLE is ignored, with no queueing. A start coincident with done is ignored. A start in the cycle after DONE (IDLE) is accepted.
- Reset mid-access drops srd/swr immediately and asynchronously; no partial access resumes.
- Overflow indication is status_b[0]=0 (peripheral valid bit). The host passes it through and takes no action on it.
- Latency for a successful job with STROBE_LEN=2, POLL_GAP=8 and ready on the first poll: 3 writes + 1 poll + 3 reads = 7 accesses × 4 cycles, plus 8 wait cycles, plus DONE = 37 cycles from the start edge to the done pulse.

Test Plan:
- arg1=3, arg2=5, start pulse, with a peripheral model -> bus trace: 0x037F←3, 0x0388←5, 0x03A0←0, poll 0x03A0, two 0x0390 reads, one 0x0398 read. Required results: result_w=0x0000000F, ones_l=4, status_b[0]=1, err=0, done pulse at cycle 37.
- arg1=arg2=0xFFFFFF -> result_w=0xFE000001, ones_l=8, status_b=2'b10 (overflow), err=0.
- Model holds status=2'b01 forever, MAX_POLLS=16 -> exactly 16 reads of 0x03A0 spaced by POLL_GAP, then done with err=1; result_w/ones_l unchanged from the previous job.
- start pulsed again during WAIT and in the done cycle -> ignored, with no extra bus writes. start one cycle later is accepted and busy rises.
- n_reset asserted mid-STROBE of the 0x0388 write -> swr falls with no clock edge, all outputs 0. After release, a new start runs the full sequence from 0x037F.
- Strobe shape check at STROBE_LEN=1 and STROBE_LEN=3 -> srd/swr high for exactly that many cycles, address stable from SETUP through HOLD, never srd&swr.
